fifo_sample_player: RTL and testbench
=====================================

Name: fifo_sample_player

Overview:
- Read-side consumer of the FIFO_memory sample FIFO in the RFSoC controller.
- Pops packed {hold, value} entries, holds each value on out_value for hold+1 cycles, and gives DAC-side logic a gapless sample stream.
- Uses a 2-entry prefetch buffer to absorb the FIFO's 1-cycle read latency, which sustains 1 entry/cycle when hold = 0.
- Flags underflow when the FIFO runs dry mid-playback.

Parameters:
- DATA_WIDTH, 32: FIFO word width; must equal the data_width of the FIFO instance.
- VALUE_WIDTH, 16: sample width, taken from bits [VALUE_WIDTH-1:0] of each entry.
- HOLD_WIDTH, DATA_WIDTH-VALUE_WIDTH: hold-count width, taken from bits [DATA_WIDTH-1:VALUE_WIDTH] of each entry.

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- reset  in  1  Asynchronous, active-low reset (0 = reset).
- start  in  1  1-cycle pulse; begin playback and clear underflow.
- stop  in  1  1-cycle pulse; finish the current entry, then go idle.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted fifo_read.
- fifo_read  out  1  FIFO read strobe (combinational).
- out_value  out  VALUE_WIDTH  Current sample.
- out_valid  out  1  out_value is a live sample this cycle.
- underflow  out  1  Sticky underflow flag.
- busy  out  1  High in any state other than IDLE.

Behaviour:
- Clocking/reset: clk only. reset is asynchronous and active-low. While reset==0:
  - state=IDLE, buffer empty, in-flight flag clear, hold counter 0;
  - out_value=0, out_valid=0, underflow=0, busy=0, fifo_read=0.
- States: IDLE, PRIME, PLAY, STARVED, DRAIN.
  - IDLE: start -> PRIME.
  - PRIME: wait for the first buffered entry. When one exists, load it into the output register -> PLAY.
  - PLAY: out_valid=1 and hold counter counts down. When the counter reaches 0:
    - buffer non-empty: load the next entry the next cycle, with no gap -> PLAY;
    - buffer empty: -> STARVED, set underflow.
  - STARVED: out_valid=0 and out_value keeps its last value. The first buffered entry loads -> PLAY.
  - DRAIN: entered when stop arrives in PLAY. Finishes the current entry's remaining cycles, then -> IDLE with out_valid=0. stop in PRIME or STARVED -> IDLE immediately.
- Entry load: out_value <= entry[VALUE_WIDTH-1:0], and the counter is set from entry[DATA_WIDTH-1:VALUE_WIDTH]. Each value is valid for exactly hold+1 cycles; the full hold range is supported and does not wrap.
- fifo_read = (state in PRIME/PLAY/STARVED) & !fifo_empty & (buffered + in_flight - consumed_this_cycle < 2).
  - At most one read is in flight.
  - The FIFO ignores reads when empty, so fifo_read is never asserted while fifo_empty=1.
- Capture: the cycle after a read, fifo_dout is written into the buffer tail. This happens unconditionally, including in DRAIN/IDLE, so no popped entry is lost.
- Buffer contents persist across stop/start; the next start plays them first.
- Latency: start pulse in cycle 0 with the FIFO non-empty gives fifo_read in cycle 1 and first out_valid in cycle 3.
- Simultaneous events:
  - start+stop in the same cycle: stop wins; stays or goes IDLE.
  - start while busy: ignored, except that it clears underflow.
  - Buffer push and pop in the same cycle are both honoured.
- No new reads are issued in DRAIN or IDLE.

Decomposition:
- Package fifo_player_pkg holds:
  - state enum player_state_t {IDLE, PRIME, PLAY, STARVED, DRAIN};
  - field-extract localparams/functions for the {hold, value} layout.
- Sub-module player_prefetch_buf: a 2-entry push/pop register FIFO.
  - Outputs: head, count[1:0].
  - Same clk/reset convention.
  - Push and pop are allowed in the same cycle.
- The top level contains the FSM, hold counter, read-credit logic and output registers.

Test Plan:
1. Reset: assert reset=0 mid-PLAY -> out_value=0, out_valid=0, fifo_read=0 and busy=0 immediately (asynchronous); after release, state stays IDLE with no reads.
2. Preload {2,0x1111},{0,0x2222},{1,0x3333}, pulse start at cycle 0 -> out_valid from cycle 3 with out_value 0x1111,0x1111,0x1111,0x2222,0x3333,0x3333. Then out_valid=0, underflow=1, out_value held at 0x3333.
3. Preload 8 entries with hold=0 and values 0..7 -> 8 consecutive out_valid cycles with values 0..7, no gaps; fifo_read never high while fifo_empty=1.
4. Preload {5,0xAAAA},{0,0xBBBB}, start, then pulse stop on the 2nd 0xAAAA cycle -> 0xAAAA shown for all 6 cycles, then IDLE. 0xBBBB stays buffered; the next start plays 0xBBBB first.
5. Start with an empty FIFO -> PRIME with no reads. Write {0,0x0042} -> out_value=0x0042 for 1 cycle, then STARVED with underflow=1. Pulse start -> underflow cleared.
6. Pulse start and stop in the same cycle -> state remains IDLE, fifo_read=0, busy=0.

Source files
------------

// File: rtl/fifo_player_pkg.sv
// Shared types and entry-layout constants for the FIFO sample player.
// An entry is packed as {hold, value}, with value in the low bits.
package fifo_player_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_VALUE_WIDTH = 16;
  localparam int unsigned DEF_HOLD_WIDTH  = DEF_DATA_WIDTH - DEF_VALUE_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    PLAY,
    STARVED,
    DRAIN
  } player_state_t;

endpackage

// File: rtl/player_prefetch_buf.sv
// Two-entry register FIFO that absorbs the sample FIFO's read latency.
// Push and pop may happen in the same cycle; head is the oldest entry.
module player_prefetch_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[0];

  // Entries shift toward slot 0 on pop; a push lands just behind the survivors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          mem[count[0]] <= din;
          count         <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            mem[0] <= din;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_sample_player.sv
// Read-side consumer of the sample FIFO: pops {hold, value} entries and
// presents each value for hold+1 cycles as a gapless stream.
module fifo_sample_player
  import fifo_player_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  output logic                   fifo_read,
  output logic [VALUE_WIDTH-1:0] out_value,
  output logic                   out_valid,
  output logic                   underflow,
  output logic                   busy
);

  localparam int unsigned HOLD_WIDTH = DATA_WIDTH - VALUE_WIDTH;

  player_state_t          state, state_nx;
  logic                   in_flight;
  logic [HOLD_WIDTH-1:0]  hold_cnt, hold_cnt_nx;
  logic [VALUE_WIDTH-1:0] out_value_nx;
  logic                   out_valid_nx;
  logic                   underflow_nx;
  logic                   busy_nx;
  logic                   load;

  logic [DATA_WIDTH-1:0]  buf_head;
  logic [1:0]             buf_count;
  logic                   buf_push;
  logic                   buf_pop;
  logic                   avail;
  logic [DATA_WIDTH-1:0]  next_entry;
  logic [1:0]             occupancy;
  logic                   active;

  // Data arriving this cycle bypasses the buffer when the buffer is empty.
  assign avail      = (buf_count != 2'd0) || in_flight;
  assign next_entry = (buf_count != 2'd0) ? buf_head : fifo_dout;
  assign buf_pop    = load && (buf_count != 2'd0);
  assign buf_push   = in_flight && !(load && (buf_count == 2'd0));

  // Read credit: buffered plus in-flight, minus what is consumed now, stays under 2.
  assign occupancy = buf_count + 2'(in_flight);
  assign active    = (state == PRIME) || (state == PLAY) || (state == STARVED);
  assign fifo_read = active && !fifo_empty && (2'(occupancy - 2'(load)) < 2'd2);

  player_prefetch_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .din   (fifo_dout),
    .pop   (buf_pop),
    .head  (buf_head),
    .count (buf_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_flight <= 1'b0;
      hold_cnt  <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
      underflow <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      in_flight <= fifo_read;
      hold_cnt  <= hold_cnt_nx;
      out_value <= out_value_nx;
      out_valid <= out_valid_nx;
      underflow <= underflow_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    load         = 1'b0;
    underflow_nx = start ? 1'b0 : underflow;

    case (state)
      IDLE: begin
        if (start && !stop) state_nx = PRIME;
      end
      PRIME, STARVED: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (avail) begin
          load     = 1'b1;
          state_nx = PLAY;
        end
      end
      PLAY: begin
        if (hold_cnt != '0) begin
          hold_cnt_nx = hold_cnt - HOLD_WIDTH'(1);
          if (stop) state_nx = DRAIN;
        end else if (stop) begin
          state_nx = IDLE;
        end else if (avail) begin
          load = 1'b1;
        end else begin
          state_nx     = STARVED;
          underflow_nx = 1'b1;
        end
      end
      DRAIN: begin
        if (hold_cnt != '0) hold_cnt_nx = hold_cnt - HOLD_WIDTH'(1);
        else                state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (load) hold_cnt_nx = next_entry[DATA_WIDTH-1:VALUE_WIDTH];
    out_value_nx = load ? next_entry[VALUE_WIDTH-1:0] : out_value;
    out_valid_nx = (state_nx == PLAY) || (state_nx == DRAIN);
    busy_nx      = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_fifo_sample_player.sv
// Directed bench for fifo_sample_player with a 1-cycle-latency FIFO model.
module tb_fifo_sample_player;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_read;
  logic [15:0] out_value;
  logic        out_valid;
  logic        underflow;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [31:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;

  always #5 clk = ~clk;

  fifo_sample_player dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .underflow  (underflow),
    .busy       (busy)
  );

  // FIFO model: data appears on fifo_dout the cycle after an accepted read.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (fifo_read && fifo_empty) viol <= viol + 1;
  end

  function automatic logic [31:0] entry(input logic [15:0] h, input logic [15:0] v);
    return {h, v};
  endfunction

  task automatic push(input logic [31:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_value !== 16'h0 || out_valid !== 1'b0 || underflow !== 1'b0 || busy !== 1'b0 || fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: val=%h valid=%b uf=%b busy=%b rd=%b required 0", out_value, out_valid, underflow, busy, fifo_read);
    end
    do_reset();
    push(entry(16'd100, 16'h5555));
    pulse_start();
    step(3);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h5555) begin
      errors++;
      $display("FAIL reset_pre_play: valid=%b val=%h required 1 5555", out_valid, out_value);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_value !== 16'h0 || out_valid !== 1'b0 || fifo_read !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: val=%h valid=%b rd=%b busy=%b required 0", out_value, out_valid, fifo_read, busy);
    end
    wr_ptr = rd_ptr;
    push(entry(16'd0, 16'h7777));
    step(2);
    reset = 1'b1;
    step(3);
    checks++;
    if (busy !== 1'b0 || fifo_read !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b rd=%b valid=%b required 0", busy, fifo_read, out_valid);
    end
  endtask

  task automatic test_hold_sequence();
    logic [15:0] exp [6] = '{16'h1111, 16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h3333};
    do_reset();
    push(entry(16'd2, 16'h1111));
    push(entry(16'd0, 16'h2222));
    push(entry(16'd1, 16'h3333));
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (fifo_read !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_latency_c1: rd=%b valid=%b required 1 0", fifo_read, out_valid);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_latency_c2: valid=%b required 0", out_valid);
    end
    step(1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_value !== exp[i]) begin
        errors++;
        $display("FAIL hold_seq[%0d]: valid=%b val=%h required 1 %h", i, out_valid, out_value, exp[i]);
      end
      step(1);
    end
    checks++;
    if (out_valid !== 1'b0 || underflow !== 1'b1 || out_value !== 16'h3333 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_starved: valid=%b uf=%b val=%h busy=%b required 0 1 3333 1", out_valid, underflow, out_value, busy);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = viol;
    for (int i = 0; i < 8; i++) push(entry(16'd0, 16'(i)));
    pulse_start();
    step(2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_value !== 16'(i)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b val=%h required 1 %h", i, out_valid, out_value, 16'(i));
      end
      step(1);
    end
    checks++;
    if (out_valid !== 1'b0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: valid=%b uf=%b required 0 1", out_valid, underflow);
    end
    checks++;
    if (viol !== base) begin
      errors++;
      $display("FAIL b2b_read_when_empty: count=%0d required %0d", viol, base);
    end
  endtask

  task automatic test_stop_drain();
    do_reset();
    push(entry(16'd5, 16'hAAAA));
    push(entry(16'd0, 16'hBBBB));
    pulse_start();
    step(2);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'hAAAA) begin
      errors++;
      $display("FAIL drain_first: valid=%b val=%h required 1 aaaa", out_valid, out_value);
    end
    step(1);
    stop = 1'b1;
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_value !== 16'hAAAA) begin
        errors++;
        $display("FAIL drain_cycle[%0d]: valid=%b val=%h required 1 aaaa", i, out_valid, out_value);
      end
      step(1);
      stop = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: valid=%b busy=%b uf=%b required 0 0 0", out_valid, busy, underflow);
    end
    step(2);
    pulse_start();
    step(1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'hBBBB) begin
      errors++;
      $display("FAIL drain_resume: valid=%b val=%h required 1 bbbb", out_valid, out_value);
    end
  endtask

  task automatic test_starve_restart();
    do_reset();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL prime_empty: busy=%b rd=%b required 1 0", busy, fifo_read);
    end
    step(2);
    checks++;
    if (fifo_read !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL prime_wait: rd=%b valid=%b required 0 0", fifo_read, out_valid);
    end
    push(entry(16'd0, 16'h0042));
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL prime_read: rd=%b required 1", fifo_read);
    end
    step(2);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 16'h0042) begin
      errors++;
      $display("FAIL starve_play: valid=%b val=%h required 1 0042", out_valid, out_value);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b0 || underflow !== 1'b1 || out_value !== 16'h0042) begin
      errors++;
      $display("FAIL starve_flag: valid=%b uf=%b val=%h required 0 1 0042", out_valid, underflow, out_value);
    end
    pulse_start();
    checks++;
    if (underflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL starve_clear: uf=%b busy=%b required 0 1", underflow, busy);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_stop: busy=%b required 0", busy);
    end
  endtask

  task automatic test_start_stop_same();
    do_reset();
    push(entry(16'd0, 16'h0099));
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_c1: busy=%b rd=%b required 0 0", busy, fifo_read);
    end
    step(2);
    checks++;
    if (busy !== 1'b0 || fifo_read !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_c3: busy=%b rd=%b valid=%b required 0 0 0", busy, fifo_read, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_hold_sequence();
    test_back_to_back();
    test_stop_drain();
    test_starve_restart();
    test_start_stop_same();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL read_while_empty_total: count=%0d required 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
